register_file_2r1w: RTL and testbench
=====================================

# register_file_2r1w

Parametrised successor to the 8x32 single-port register file: a DEPTH x DATA_W storage array with one byte-masked write port and two independent registered read ports. Same-cycle write-to-read bypass, an optional hardwired-zero entry 0, and a sequential bulk-clear engine with a busy flag. Intended as the operand register bank for the datapath blocks that follow, which need two operands per cycle.

## Interface
- DATA_W, 32, word width in bits; must be a multiple of 8
- DEPTH, 8, number of entries; must be ≥ 2, need not be a power of two
- ADDR_W, $clog2(DEPTH), address width (derived; do not override)
- ZERO_REG, 0, when 1, entry 0 always reads 0 and ignores writes
- clk  input  1  single clock, rising-edge active
- reset_n  input  1  asynchronous, active-low reset
- we  input  1  write enable
- wAddr  input  ADDR_W  write address
- wData  input  DATA_W  write data
- wBe  input  DATA_W/8  byte enables; bit i covers wData[8i+7:8i]
- rAddrA  input  ADDR_W  read port A address
- rDataA  output  DATA_W  read port A data, registered
- rAddrB  input  ADDR_W  read port B address
- rDataB  output  DATA_W  read port B data, registered
- clr  input  1  one-cycle request to zero all entries
- busy  output  1  high while the clear sweep runs

## Operation
- Reset (reset_n low, asynchronous): all entries = 0, rDataA = rDataB = 0, busy = 0, FSM = IDLE, sweep counter = 0.
- Write: at a rising edge with we=1, busy=0, and wAddr < DEPTH, byte i of entry wAddr takes wData byte i for each wBe[i]=1. Unselected bytes hold. we with wBe=0 is a no-op.
- Ignored writes:
  - wAddr ≥ DEPTH.
  - wAddr = 0 when ZERO_REG=1.
  - Any write while busy=1.
- Read: at each rising edge, each port registers the entry at its address into rDataX. The two ports are fully independent; equal addresses are legal.
- Reads return 0 when:
  - rAddrX ≥ DEPTH;
  - rAddrX = 0 with ZERO_REG=1;
  - busy=1 at that edge.
- Bypass: if a read address equals an accepted write's wAddr at the same edge, rDataX gets the post-write merged value: written bytes from wData, other bytes from the old entry. This applies to both ports at once.
- Clear FSM, states IDLE and CLEAR:
  - IDLE -> CLEAR at a rising edge with clr=1. busy goes 1 and the counter is set to 0.
  - In CLEAR, each edge writes 0 to entry[counter] and increments the counter.
  - After the edge that clears entry DEPTH-1, the FSM returns to IDLE and busy goes 0.
  - clr while busy=1 is ignored; the sweep does not restart.
- clr and we at the same edge in IDLE: the write is ignored and the clear starts.
- reset_n asserted mid-sweep: immediate return to reset state, with all entries 0.

## Timing
- Write latency 1 edge. Data written at edge N is visible through a read sampled at edge N (via bypass) or at any later edge.
- Read latency 1: an address presented before edge N gives rDataX valid after edge N, held until the next edge.
- Clear duration is exactly DEPTH cycles. busy rises after the clr edge and falls after the DEPTH-th sweep edge.
- The first write is accepted at the edge after busy falls.
- No combinational path from any input to any output.

## Test plan
- **Reset and basic write/read** (DEPTH=8, DATA_W=32):
  - Hold reset_n=0 and check every output = 0.
  - Release, then write 32'h1111_0000 to entry 0, 32'hABCD_1234 to entry 1 and 32'hFFFF_9999 to entry 3, all with wBe=4'hF.
  - Read port A at 1 and port B at 3 at the same edge -> 32'hABCD_1234 and 32'hFFFF_9999 one cycle later.
- **Byte mask and bypass**:
  - Entry 2 holds 32'h1234_5678. Write wData=32'hAABB_CCDD, wBe=4'b0101, with rAddrA=rAddrB=2 at the same edge.
  - Both ports -> 32'h12BB_56DD after that edge, and the entry holds that value afterwards.
- **ZERO_REG=1**:
  - Write 32'hDEAD_BEEF to entry 0 -> reads of entry 0 return 0.
  - Same write to entry 5 -> reads of entry 5 return 32'hDEAD_BEEF.
- **Clear sweep**:
  - Fill all 8 entries with nonzero data, then pulse clr.
  - busy is high for exactly 8 cycles, and reads during busy return 0.
  - A write issued during busy is dropped, and a second clr mid-sweep does not extend busy.
  - After busy falls, all entries read 0.
- **Reset mid-sweep and edge addressing** (DEPTH=6):
  - Assert reset_n=0 during the 3rd sweep cycle -> busy=0 and outputs 0 immediately.
  - Write to wAddr=7 is ignored, and a read of rAddrA=6 returns 0.
- **Simultaneous clr and we**:
  - At the same edge, write 32'h5555_AAAA to entry 4 and assert clr.
  - The write is lost, and entry 4 reads 0 after the sweep.

Source files
------------

// File: rtl/register_file_2r1w_if.sv
// Operand bank port bundle: one byte-masked write port, two read ports, clear control.
// Latency: n/a (wiring only).
// Backpressure: none; the bank signals its clear sweep through busy.
interface register_file_2r1w_if #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 3
);
    logic                  we;
    logic [ADDR_W-1:0]     wAddr;
    logic [DATA_W-1:0]     wData;
    logic [DATA_W/8-1:0]   wBe;
    logic [ADDR_W-1:0]     rAddrA;
    logic [DATA_W-1:0]     rDataA;
    logic [ADDR_W-1:0]     rAddrB;
    logic [DATA_W-1:0]     rDataB;
    logic                  clr;
    logic                  busy;

    // Requester side: drives writes, read addresses and clear requests.
    modport master (
        output we, wAddr, wData, wBe, rAddrA, rAddrB, clr,
        input  rDataA, rDataB, busy
    );

    // Register bank side.
    modport slave (
        input  we, wAddr, wData, wBe, rAddrA, rAddrB, clr,
        output rDataA, rDataB, busy
    );
endinterface

// File: rtl/register_file_2r1w.sv
// DEPTH x DATA_W operand register bank: byte-masked write, two registered reads, bulk clear.
// Latency: 1 edge for write and reads; same-edge write is bypassed into both read ports.
// Backpressure: busy high for DEPTH cycles after clr; writes dropped and reads return 0 meanwhile.
module register_file_2r1w #(
    parameter int DATA_W   = 32,
    parameter int DEPTH    = 8,
    parameter int ADDR_W   = $clog2(DEPTH),
    parameter bit ZERO_REG = 1'b0
) (
    input  logic                 clk,
    input  logic                 reset_n,
    register_file_2r1w_if.slave  bus
);

    localparam int NB = DATA_W / 8;
    localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(DEPTH - 1);

    typedef enum logic {
        IDLE  = 1'b0,
        CLEAR = 1'b1
    } state_t;

    state_t              state;
    logic [ADDR_W-1:0]   sweepCnt;
    logic                busyQ;

    logic [DATA_W-1:0]   mem [DEPTH];

    logic                wrAccept;
    logic [DATA_W-1:0]   oldWord;
    logic [DATA_W-1:0]   mergedWord;
    logic [DATA_W-1:0]   nextA;
    logic [DATA_W-1:0]   nextB;
    logic [DATA_W-1:0]   rDataAQ;
    logic [DATA_W-1:0]   rDataBQ;

    // Address maps to a real, writable/readable entry (not past the end, not the hardwired zero).
    function automatic logic addrOk(input logic [ADDR_W-1:0] a);
        return (int'(a) < DEPTH) && !(ZERO_REG && (a == '0));
    endfunction

    // Write acceptance: a clear request at the same edge wins over the write.
    assign wrAccept = bus.we && !busyQ && !bus.clr && addrOk(bus.wAddr);

    // Merge the written bytes into the current entry contents.
    always_comb begin
        oldWord    = addrOk(bus.wAddr) ? mem[bus.wAddr] : '0;
        mergedWord = oldWord;
        for (int i = 0; i < NB; i++) begin
            if (bus.wBe[i]) begin
                mergedWord[8*i +: 8] = bus.wData[8*i +: 8];
            end
        end
    end

    // Read-port selection: zero while sweeping or for invalid addresses, bypass on address hit.
    always_comb begin
        nextA = '0;
        nextB = '0;
        if (!busyQ && addrOk(bus.rAddrA)) begin
            nextA = (wrAccept && (bus.rAddrA == bus.wAddr)) ? mergedWord : mem[bus.rAddrA];
        end
        if (!busyQ && addrOk(bus.rAddrB)) begin
            nextB = (wrAccept && (bus.rAddrB == bus.wAddr)) ? mergedWord : mem[bus.rAddrB];
        end
    end

    // Storage: one register per entry, cleared by reset or by the sweep, else loaded on accepted write.
    for (genvar g = 0; g < DEPTH; g++) begin : gEntry
        always_ff @(posedge clk or negedge reset_n) begin
            if (!reset_n) begin
                mem[g] <= '0;
            end else if (busyQ && (sweepCnt == ADDR_W'(g))) begin
                mem[g] <= '0;
            end else if (wrAccept && (bus.wAddr == ADDR_W'(g))) begin
                mem[g] <= mergedWord;
            end
        end
    end

    // Clear sequencer: one entry per cycle from 0 to DEPTH-1; clr during a sweep is ignored.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state    <= IDLE;
            sweepCnt <= '0;
            busyQ    <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.clr) begin
                        state    <= CLEAR;
                        sweepCnt <= '0;
                        busyQ    <= 1'b1;
                    end
                end
                CLEAR: begin
                    if (sweepCnt == LAST_IDX) begin
                        state    <= IDLE;
                        sweepCnt <= '0;
                        busyQ    <= 1'b0;
                    end else begin
                        sweepCnt <= sweepCnt + ADDR_W'(1);
                    end
                end
                default: begin
                    state    <= IDLE;
                    sweepCnt <= '0;
                    busyQ    <= 1'b0;
                end
            endcase
        end
    end

    // Registered read data for both ports.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rDataAQ <= '0;
            rDataBQ <= '0;
        end else begin
            rDataAQ <= nextA;
            rDataBQ <= nextB;
        end
    end

    assign bus.rDataA = rDataAQ;
    assign bus.rDataB = rDataBQ;
    assign bus.busy   = busyQ;

endmodule

// File: tb/tb_register_file_2r1w.sv
// Bench for the operand register bank: three instances driven in lockstep
// (8 entries, 8 entries with hardwired zero, 6 entries) against an array-based model.
// Directed steps from the bank's feature list, followed by a randomized phase.
module tb_register_file_2r1w;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        we;
    logic [2:0]  wAddr;
    logic [31:0] wData;
    logic [3:0]  wBe;
    logic [2:0]  rAddrA;
    logic [2:0]  rAddrB;
    logic        clr;

    always #5 clk = ~clk;

    register_file_2r1w_if #(.DATA_W(32), .ADDR_W(3)) bus0 ();
    register_file_2r1w_if #(.DATA_W(32), .ADDR_W(3)) bus1 ();
    register_file_2r1w_if #(.DATA_W(32), .ADDR_W(3)) bus2 ();

    assign bus0.we = we;  assign bus0.wAddr = wAddr;  assign bus0.wData = wData;  assign bus0.wBe = wBe;
    assign bus0.rAddrA = rAddrA;  assign bus0.rAddrB = rAddrB;  assign bus0.clr = clr;
    assign bus1.we = we;  assign bus1.wAddr = wAddr;  assign bus1.wData = wData;  assign bus1.wBe = wBe;
    assign bus1.rAddrA = rAddrA;  assign bus1.rAddrB = rAddrB;  assign bus1.clr = clr;
    assign bus2.we = we;  assign bus2.wAddr = wAddr;  assign bus2.wData = wData;  assign bus2.wBe = wBe;
    assign bus2.rAddrA = rAddrA;  assign bus2.rAddrB = rAddrB;  assign bus2.clr = clr;

    register_file_2r1w #(.DATA_W(32), .DEPTH(8), .ZERO_REG(1'b0)) dut0 (.clk(clk), .reset_n(reset_n), .bus(bus0));
    register_file_2r1w #(.DATA_W(32), .DEPTH(8), .ZERO_REG(1'b1)) dut1 (.clk(clk), .reset_n(reset_n), .bus(bus1));
    register_file_2r1w #(.DATA_W(32), .DEPTH(6), .ZERO_REG(1'b0)) dut2 (.clk(clk), .reset_n(reset_n), .bus(bus2));

    logic [31:0] oA [3];
    logic [31:0] oB [3];
    logic        oBusy [3];
    assign oA[0] = bus0.rDataA;  assign oB[0] = bus0.rDataB;  assign oBusy[0] = bus0.busy;
    assign oA[1] = bus1.rDataA;  assign oB[1] = bus1.rDataB;  assign oBusy[1] = bus1.busy;
    assign oA[2] = bus2.rDataA;  assign oB[2] = bus2.rDataB;  assign oBusy[2] = bus2.busy;

    // Reference model: plain word arrays, a remaining-sweep-cycles count, expected read data.
    int          depthOf [3];
    bit          zrOf [3];
    logic [31:0] m [3][8];
    int          left [3];
    logic [31:0] eA [3];
    logic [31:0] eB [3];

    int checks;
    int errors;
    int busyCnt;

    function automatic logic [31:0] mRead(int k, logic [2:0] a, bit sweeping);
        if (sweeping || int'(a) >= depthOf[k] || (zrOf[k] && a == 3'd0)) return 32'h0;
        return m[k][a];
    endfunction

    task automatic modelReset();
        for (int k = 0; k < 3; k++) begin
            for (int i = 0; i < 8; i++) m[k][i] = 32'h0;
            left[k] = 0;
            eA[k]   = 32'h0;
            eB[k]   = 32'h0;
        end
    endtask

    // Advance the model by one rising edge using the currently driven inputs.
    task automatic modelEdge();
        if (!reset_n) begin
            modelReset();
            return;
        end
        for (int k = 0; k < 3; k++) begin
            bit sweeping;
            sweeping = (left[k] > 0);
            if (we && !sweeping && !clr && int'(wAddr) < depthOf[k] && !(zrOf[k] && wAddr == 3'd0)) begin
                for (int j = 0; j < 4; j++) begin
                    if (wBe[j]) m[k][wAddr][8*j +: 8] = wData[8*j +: 8];
                end
            end
            eA[k] = mRead(k, rAddrA, sweeping);
            eB[k] = mRead(k, rAddrB, sweeping);
            if (sweeping) begin
                left[k] = left[k] - 1;
            end else if (clr) begin
                left[k] = depthOf[k];
                for (int i = 0; i < 8; i++) m[k][i] = 32'h0;
            end
        end
    endtask

    task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic checkAll(string tag);
        for (int k = 0; k < 3; k++) begin
            chk($sformatf("%s dut%0d rDataA", tag, k), oA[k], eA[k]);
            chk($sformatf("%s dut%0d rDataB", tag, k), oB[k], eB[k]);
            chk($sformatf("%s dut%0d busy", tag, k), {31'b0, oBusy[k]}, (left[k] > 0) ? 32'd1 : 32'd0);
        end
    endtask

    task automatic tick(string tag);
        modelEdge();
        @(posedge clk);
        #1;
        checkAll(tag);
    endtask

    task automatic wr(logic [2:0] a, logic [31:0] d, logic [3:0] be);
        we = 1'b1;  wAddr = a;  wData = d;  wBe = be;
        tick($sformatf("wr%0d", a));
        we = 1'b0;  wBe = 4'h0;
    endtask

    initial begin
        depthOf[0] = 8;  depthOf[1] = 8;  depthOf[2] = 6;
        zrOf[0] = 1'b0;  zrOf[1] = 1'b1;  zrOf[2] = 1'b0;
        checks = 0;  errors = 0;
        reset_n = 1'b0;  we = 1'b0;  wAddr = 3'd0;  wData = 32'h0;  wBe = 4'h0;
        rAddrA = 3'd0;  rAddrB = 3'd0;  clr = 1'b0;
        modelReset();

        // Reset holds every output at zero.
        tick("reset");
        tick("reset");
        chk("reset rDataA", oA[0], 32'h0);
        chk("reset busy", {31'b0, oBusy[0]}, 32'h0);
        reset_n = 1'b1;

        // Basic write then dual read.
        wr(3'd0, 32'h1111_0000, 4'hF);
        wr(3'd1, 32'hABCD_1234, 4'hF);
        wr(3'd3, 32'hFFFF_9999, 4'hF);
        rAddrA = 3'd1;  rAddrB = 3'd3;
        tick("rd13");
        chk("rd port A entry1", oA[0], 32'hABCD_1234);
        chk("rd port B entry3", oB[0], 32'hFFFF_9999);
        rAddrA = 3'd0;
        tick("rd0");
        chk("rd entry0 plain", oA[0], 32'h1111_0000);
        chk("rd entry0 zeroreg", oA[1], 32'h0);

        // Byte-masked write with same-edge bypass on both ports.
        wr(3'd2, 32'h1234_5678, 4'hF);
        rAddrA = 3'd2;  rAddrB = 3'd2;
        we = 1'b1;  wAddr = 3'd2;  wData = 32'hAABB_CCDD;  wBe = 4'b0101;
        tick("bypass");
        we = 1'b0;  wBe = 4'h0;
        chk("bypass port A", oA[0], 32'h12BB_56DD);
        chk("bypass port B", oB[0], 32'h12BB_56DD);
        tick("held");
        chk("merged held", oA[0], 32'h12BB_56DD);

        // Hardwired zero entry.
        wr(3'd0, 32'hDEAD_BEEF, 4'hF);
        wr(3'd5, 32'hDEAD_BEEF, 4'hF);
        rAddrA = 3'd0;  rAddrB = 3'd5;
        tick("zeroreg");
        chk("zeroreg entry0", oA[1], 32'h0);
        chk("zeroreg entry5", oB[1], 32'hDEAD_BEEF);
        chk("plain entry0", oA[0], 32'hDEAD_BEEF);

        // Clear sweep: busy exactly 8 cycles, dropped write, ignored second clr.
        for (int i = 0; i < 8; i++) wr(3'(i), 32'h0101_0101 * (i + 1), 4'hF);
        clr = 1'b1;
        tick("clr");
        clr = 1'b0;
        busyCnt = oBusy[0] ? 1 : 0;
        for (int c = 0; c < 12; c++) begin
            if (c == 3) begin
                we = 1'b1;  wAddr = 3'd1;  wData = 32'hCAFE_F00D;  wBe = 4'hF;
            end
            if (c == 4) clr = 1'b1;
            rAddrA = 3'(c);  rAddrB = 3'd1;
            tick("sweep");
            if (oBusy[0]) busyCnt++;
            we = 1'b0;  wBe = 4'h0;  clr = 1'b0;
        end
        chk("busy cycle count", 32'(busyCnt), 32'd8);
        for (int i = 0; i < 8; i++) begin
            rAddrA = 3'(i);  rAddrB = 3'(7 - i);
            tick("postclr");
            chk("postclr entry", oA[0], 32'h0);
        end

        // Simultaneous clr and write: write lost, no bypass.
        rAddrA = 3'd4;
        we = 1'b1;  wAddr = 3'd4;  wData = 32'h5555_AAAA;  wBe = 4'hF;  clr = 1'b1;
        tick("clrwe");
        we = 1'b0;  wBe = 4'h0;  clr = 1'b0;
        for (int c = 0; c < 9; c++) tick("clrwe sweep");
        tick("clrwe read");
        chk("clrwe entry4", oA[0], 32'h0);

        // Reset during the third sweep cycle.
        for (int i = 0; i < 8; i++) wr(3'(i), 32'h7070_0000 + 32'(i), 4'hF);
        clr = 1'b1;
        tick("clr2");
        clr = 1'b0;
        tick("sweep2");
        tick("sweep2");
        #2;
        reset_n = 1'b0;
        modelReset();
        #1;
        checkAll("midreset");
        chk("midreset busy dut2", {31'b0, oBusy[2]}, 32'h0);
        tick("inreset");
        reset_n = 1'b1;
        for (int i = 0; i < 8; i++) begin
            rAddrA = 3'(i);  rAddrB = 3'(i);
            tick("afterreset");
        end

        // Out-of-range addressing on the 6-entry instance.
        rAddrA = 3'd6;  rAddrB = 3'd7;
        wr(3'd7, 32'h7777_7777, 4'hF);
        tick("oor");
        chk("oor read6 dut2", oA[2], 32'h0);
        chk("oor read7 dut2", oB[2], 32'h0);
        chk("oor read7 dut0", oB[0], 32'h7777_7777);

        // Randomized traffic against the model.
        for (int c = 0; c < 400; c++) begin
            we     = ($urandom_range(0, 1) == 1);
            wAddr  = 3'($urandom_range(0, 7));
            wData  = $urandom;
            wBe    = 4'($urandom_range(0, 15));
            rAddrA = 3'($urandom_range(0, 7));
            rAddrB = ($urandom_range(0, 3) == 0) ? wAddr : 3'($urandom_range(0, 7));
            clr    = ($urandom_range(0, 49) == 0);
            tick("random");
        end
        we = 1'b0;  clr = 1'b0;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
